mult_div_unit: RTL and testbench

Multi-cycle signed multiply/divide unit with 32-bit HI/LO result registers, as used by the pipelined MIPS CPU's execute stage. A one-cycle `start` pulse launches an operation; `busy` stays high for a fixed latency. On completion the 64-bit product, or the quotient/remainder, is committed to HI/LO. The pipeline stalls on `busy` before issuing further HI/LO-dependent instructions.

---
 rtl/mult_div_unit_if.sv | 15 +
 rtl/mult_div_unit.sv | 104 ++++++++++
 tb/tb_mult_div_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Handshake/result bundle between the execute stage and the multiply/divide unit.
// Ports: start/op/A/B launch an operation; busy/HI/LO report status and results.
// Master = pipeline side (drives the launch), slave = the unit (drives status/results).
interface mult_div_unit_if;
    logic        start;
    logic        op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output start, op, A, B, input busy, HI, LO);
    modport slave  (input start, op, A, B, output busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// Signed 32x32 multiply / 32/32 divide unit committing results to HI/LO.
// Latency: multiply 5 cycles, divide 10 cycles from the accepting edge; busy is registered.
// Backpressure: a start seen while busy is dropped; caller stalls on busy.
// Ports: clk, reset (sync, active-high), bus (slave: start/op/A/B in, busy/HI/LO out).
module mult_div_unit (
    input  logic              clk,
    input  logic              reset,
    mult_div_unit_if.slave    bus
);
    localparam logic [3:0] MULT_LAT = 4'd5;
    localparam logic [3:0] DIV_LAT  = 4'd10;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, b_q;
    logic        op_q;
    logic [31:0] hi_q, lo_q;
    logic        load;
    logic        done;

    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;

    // Result is formed from the latched operands and only used on the completing edge.
    always_comb begin
        prod = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        quo  = 32'd0;
        rem  = 32'd0;
        if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
            // The one quotient that does not fit: wrap to INT_MIN with zero remainder.
            quo = 32'h8000_0000;
            rem = 32'd0;
        end else if (b_q != 32'd0) begin
            quo = $signed(a_q) / $signed(b_q);
            rem = $signed(a_q) % $signed(b_q);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                    cnt_d   = bus.op ? DIV_LAT : MULT_LAT;
                end
            end
            RUN: begin
                // Counter holds the cycles left including the current one.
                if (cnt_q == 4'd1) begin
                    done    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                a_q  <= bus.A;
                b_q  <= bus.B;
                op_q <= bus.op;
            end
            if (done) begin
                if (!op_q) begin
                    hi_q <= prod[63:32];
                    lo_q <= prod[31:0];
                end else if (b_q != 32'd0) begin
                    hi_q <= rem;
                    lo_q <= quo;
                end
            end
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: scoreboard of expected {HI,LO} pushed at launch,
// popped and compared when busy falls; also checks latency, HI/LO hold and reset.
module tb_mult_div_unit;
    logic clk;
    logic reset;
    int   tests;
    int   fails;
    logic [63:0] sb_q[$];

    mult_div_unit_if bus ();

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Independent reference: sign-magnitude multiply and shift-subtract divide.
    function automatic logic [63:0] model(input logic o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] prev);
        logic [63:0] ma, mb, p, r;
        logic [31:0] q;
        logic        na, nb;
        na = a[31];
        nb = b[31];
        ma = {32'd0, na ? -a : a};
        mb = {32'd0, nb ? -b : b};
        if (!o) begin
            p = 64'd0;
            for (int i = 0; i < 32; i++)
                if (mb[i]) p = p + (ma << i);
            return (na ^ nb) ? -p : p;
        end
        if (b == 32'd0) return prev;
        r = 64'd0;
        q = 32'd0;
        for (int i = 31; i >= 0; i--) begin
            r = {r[62:0], ma[i]};
            if (r >= mb) begin
                r = r - mb;
                q[i] = 1'b1;
            end
        end
        if (na ^ nb) q = -q;
        if (na) r = -r;
        return {r[31:0], q};
    endfunction

    task automatic launch(input logic o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        bus.op    = $urandom_range(0, 1);
    endtask

    // inject: 1 = start 2 cycles in, 2 = start on the last busy cycle (edge where busy falls).
    task automatic wait_done(input string tag, input int lat, input int inject);
        int n;
        logic [31:0] hi0, lo0;
        logic [63:0] exp;
        n   = 0;
        hi0 = bus.HI;
        lo0 = bus.LO;
        while (bus.busy && n < 100) begin
            n++;
            check({tag, "_hold"}, {bus.HI, bus.LO}, {hi0, lo0});
            if ((inject == 1 && n == 2) || (inject == 2 && n == lat)) begin
                bus.start = 1'b1;
                bus.op    = 1'b1;
                bus.A     = 32'h7777_0000;
                bus.B     = 32'h0000_0003;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_busy_low"}, {63'd0, bus.busy}, 64'd0);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            exp = sb_q.pop_front();
            check({tag, "_hilo"}, {bus.HI, bus.LO}, exp);
        end
    endtask

    task automatic run(input string tag, input logic o, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input int inject);
        sb_q.push_back(exp);
        launch(o, a, b);
        wait_done(tag, o ? 10 : 5, inject);
    endtask

    initial begin
        logic [31:0] ra, rb;
        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        check("reset_state", {31'd0, bus.busy, bus.HI}, 64'd0);
        check("reset_lo", {32'd0, bus.LO}, 64'd0);

        run("div_basic", 1'b1, 32'h0000_1234, 32'h0000_0012, {32'h0000_0010, 32'h0000_0102}, 0);
        run("div_by_zero", 1'b1, 32'd5, 32'd0, {32'h0000_0010, 32'h0000_0102}, 0);
        run("mul_basic", 1'b0, 32'h0000_1234, 32'h0000_1212, {32'h0, 32'h0148_EFA8}, 0);
        run("mul_neg", 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 0);
        run("div_neg", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
        run("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 0);
        run("mul_busy_start", 1'b0, 32'h0000_0003, 32'h0000_0007, {32'h0, 32'h0000_0015}, 1);
        run("div_edge_start", 1'b1, 32'h0000_0064, 32'hFFFF_FFF9, {32'h0000_0002, 32'hFFFF_FFF2}, 2);
        run("mul_b2b", 1'b0, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0}, 0);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (rb == 32'd0) rb = 32'd1;
            if (i[0]) rb = {{20{rb[31]}}, rb[11:0]} | 32'd1;
            run("rand", i[0], ra, rb, model(i[0], ra, rb, {bus.HI, bus.LO}), 0);
        end

        // Reset mid-operation aborts and clears.
        launch(1'b0, 32'h0000_1234, 32'h0000_1212);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_mid_hilo", {bus.HI, bus.LO}, 64'd0);

        // Reset together with start: nothing starts.
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.A     = 32'd9;
        bus.B     = 32'd9;
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        check("rst_start_busy", {63'd0, bus.busy}, 64'd0);
        repeat (6) @(negedge clk);
        check("rst_start_hilo", {bus.HI, bus.LO}, 64'd0);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
